// File: rtl/irq_injector.sv
// irq_injector: latches per-source interrupt requests and injects them as addi words into fetch; IRQ_ROUND_ROBIN_EN selects round-robin arbitration
module irq_injector #(
  parameter int         NUM_SRC  = 4,
  parameter logic [4:0] BASE_REG = 5'd20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   irq_req,
  input  logic [16*NUM_SRC-1:0] irq_payload,
  input  logic                 should_stall_decode,
  input  logic                 should_jump,
  input  logic                 irq_clear_dropped,
  output logic [31:0]          interrupt_instruction,
  output logic [NUM_SRC-1:0]   irq_pending,
  output logic [NUM_SRC-1:0]   irq_dropped
);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic {IDLE, INJECT} state_t;
  state_t state, state_nx;
  logic [NUM_SRC-1:0] pending, dropped, hit;
  logic [15:0] payload [NUM_SRC];
  logic [SW-1:0] sel, win;
  logic [31:0] word;
  logic clean, start, accept;
  assign clean = !should_stall_decode && !should_jump;
  assign irq_pending = pending;
  assign irq_dropped = dropped;
  // state register; reset discards any in-flight injection
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state and output word; a stall or jump blocks both launch and acceptance
  always_comb begin
    state_nx = state;
    start = 1'b0;
    accept = 1'b0;
    interrupt_instruction = 32'd0;
    if (state == IDLE) begin
      start = |pending && clean;
      state_nx = start ? INJECT : IDLE;
    end else begin
      interrupt_instruction = word;
      accept = clean;
      state_nx = clean ? IDLE : INJECT;
    end
  end
`ifdef IRQ_ROUND_ROBIN_EN
  logic [SW-1:0] ptr;
  // round-robin search starting just after the last accepted source
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (pending[(int'(ptr) + k) % NUM_SRC]) win = SW'((int'(ptr) + k) % NUM_SRC);
  end
  // pointer advances only when an injection is accepted
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr <= '0;
    else if (accept) ptr <= (int'(sel) == NUM_SRC - 1) ? '0 : sel + 1'b1;
`else
  // fixed priority, lowest index wins
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (pending[k]) win = SW'(k);
  end
`endif
  // one-hot of the source whose word is accepted this edge
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_SRC; k++) hit[k] = accept && (sel == SW'(k));
  end
  // capture the winner and its addi word at launch; held unchanged until accepted
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sel <= '0;
      word <= 32'd0;
    end else if (start) begin
      sel <= win;
      word <= {5'b00101, BASE_REG + 5'(win), 5'd0, 1'b0, payload[win]};
    end
  // per-source pending/payload latch and sticky overrun flag
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pending <= '0;
      dropped <= '0;
      for (int k = 0; k < NUM_SRC; k++) payload[k] <= 16'd0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (irq_req[k] && (!pending[k] || hit[k])) begin
          pending[k] <= 1'b1;
          payload[k] <= irq_payload[16*k +: 16];
        end else if (hit[k]) pending[k] <= 1'b0;
        if (irq_clear_dropped) dropped[k] <= 1'b0;
        else if (irq_req[k] && pending[k] && !hit[k]) dropped[k] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_irq_injector.sv
// tb_irq_injector: directed self-checking bench for irq_injector
module tb_irq_injector;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] irq_req = '0;
  logic [16*N-1:0] irq_payload = '0;
  logic should_stall_decode = 1'b0;
  logic should_jump = 1'b0;
  logic irq_clear_dropped = 1'b0;
  logic [31:0] interrupt_instruction;
  logic [N-1:0] irq_pending, irq_dropped;
  logic [31:0] ord [3];
  int n_chk = 0;
  int n_pass = 0;
  irq_injector #(.NUM_SRC(N), .BASE_REG(5'd20)) dut (
    .clock(clock),
    .reset(reset),
    .irq_req(irq_req),
    .irq_payload(irq_payload),
    .should_stall_decode(should_stall_decode),
    .should_jump(should_jump),
    .irq_clear_dropped(irq_clear_dropped),
    .interrupt_instruction(interrupt_instruction),
    .irq_pending(irq_pending),
    .irq_dropped(irq_dropped)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic req(input int s, input logic [15:0] p);
    irq_req[s] = 1'b1;
    irq_payload[16*s +: 16] = p;
  endtask
  initial begin
    #12;
    check("rst_word", interrupt_instruction, 32'd0);
    check("rst_pend", 32'(irq_pending), 32'd0);
    check("rst_drop", 32'(irq_dropped), 32'd0);
    reset = 1'b1;
    tick();
    // single request on source 2
    req(2, 16'h00AB);
    tick();
    irq_req = '0;
    check("single_pend", 32'(irq_pending), 32'h4);
    check("single_idle", interrupt_instruction, 32'd0);
    tick();
    check("single_word", interrupt_instruction, 32'h2D8000AB);
    tick();
    check("single_gone", interrupt_instruction, 32'd0);
    check("single_clr", 32'(irq_pending), 32'd0);
    tick();
    check("single_gap", interrupt_instruction, 32'd0);
    // decode stall for three cycles while injecting
    req(0, 16'h0005);
    tick();
    irq_req = '0;
    tick();
    check("stall_word", interrupt_instruction, 32'h2D000005);
    should_stall_decode = 1'b1;
    repeat (3) begin
      tick();
      check("stall_hold", interrupt_instruction, 32'h2D000005);
    end
    should_stall_decode = 1'b0;
    tick();
    check("stall_done", interrupt_instruction, 32'd0);
    check("stall_pend", 32'(irq_pending), 32'd0);
    // jump redirect for one cycle while injecting
    req(0, 16'h0005);
    tick();
    irq_req = '0;
    tick();
    check("jump_word", interrupt_instruction, 32'h2D000005);
    should_jump = 1'b1;
    tick();
    check("jump_hold", interrupt_instruction, 32'h2D000005);
    should_jump = 1'b0;
    tick();
    check("jump_done", interrupt_instruction, 32'd0);
    check("jump_pend", 32'(irq_pending), 32'd0);
    // overrun on source 1 keeps the first payload
    req(1, 16'h0001);
    tick();
    req(1, 16'h0002);
    tick();
    irq_req = '0;
    check("ovr_drop", 32'(irq_dropped), 32'h2);
    check("ovr_word", interrupt_instruction, 32'h2D400001);
    tick();
    check("ovr_gone", interrupt_instruction, 32'd0);
    check("ovr_pend", 32'(irq_pending), 32'd0);
    check("ovr_sticky", 32'(irq_dropped), 32'h2);
    irq_clear_dropped = 1'b1;
    tick();
    irq_clear_dropped = 1'b0;
    check("ovr_clear", 32'(irq_dropped), 32'd0);
    // serve source 0 alone, then simultaneous requests on 0, 1, 3
    req(0, 16'h0020);
    tick();
    irq_req = '0;
    tick();
    check("arb_pre", interrupt_instruction, 32'h2D000020);
    tick();
    req(0, 16'h0010);
    req(1, 16'h0011);
    req(3, 16'h0013);
    tick();
    irq_req = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    ord[0] = 32'h2D400011;
    ord[1] = 32'h2DC00013;
    ord[2] = 32'h2D000010;
`else
    ord[0] = 32'h2D000010;
    ord[1] = 32'h2D400011;
    ord[2] = 32'h2DC00013;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("arb_word%0d", i), interrupt_instruction, ord[i]);
      tick();
      check($sformatf("arb_gap%0d", i), interrupt_instruction, 32'd0);
    end
    check("arb_pend", 32'(irq_pending), 32'd0);
    // asynchronous reset while a word is being driven
    req(2, 16'h00AB);
    tick();
    irq_req = '0;
    tick();
    check("mid_word", interrupt_instruction, 32'h2D8000AB);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_word", interrupt_instruction, 32'd0);
    check("mid_rst_pend", 32'(irq_pending), 32'd0);
    repeat (2) tick();
    #3 reset = 1'b1;
    repeat (4) begin
      tick();
      check("post_rst_idle", interrupt_instruction, 32'd0);
    end
    check("post_rst_pend", 32'(irq_pending), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
